// File: rtl/crossbar_staged_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_staged_pkg
// Shared definitions for the staged crossbar:
//   ROUTE_NONE     canonical "no source" entry value (-1)
//   idx_in_range   full-width signed check 0 <= idx < limit
//   idx_normalise  returns idx when in range, otherwise ROUTE_NONE
// Indices are handled as 32-bit signed values so a narrower W-bit index is
// sign-extended before it is compared and never truncated.
// ---------------------------------------------------------------------------
package crossbar_staged_pkg;

   localparam logic signed [31:0] ROUTE_NONE = -32'sd1;

   function automatic logic idx_in_range(
      input logic signed [31:0] idx,
      input logic signed [31:0] limit
   );
      logic ok;
      if ((idx >= 32'sd0) && (idx < limit)) begin
         ok = 1'b1;
      end else begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic signed [31:0] idx_normalise(
      input logic signed [31:0] idx,
      input logic signed [31:0] limit
   );
      logic signed [31:0] res;
      if (idx_in_range(idx, limit)) begin
         res = idx;
      end else begin
         res = ROUTE_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/crossbar_route_reg.sv
// ---------------------------------------------------------------------------
// crossbar_route_reg
// One output lane of the staged crossbar: shadow entry, active entry and the
// registered output channel.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   in           all N input channels, channel i = in[i*D +: D]
//   put_hit      this lane is the target of a put at this edge
//   put_value    normalised source index to store
//   commit       load active from shadow at this edge
//   active       current active entry
//   shadow_next  shadow entry as it will be after this edge
//   active_next  active entry as it will be after this edge
//   out          registered output channel (D bits)
// ---------------------------------------------------------------------------
module crossbar_route_reg
   import crossbar_staged_pkg::*;
#(
   parameter int W         = 3,
   parameter int N         = 4,
   parameter int D         = 1,
   parameter int IMMEDIATE = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N*D-1:0]      in,
   input  logic                put_hit,
   input  logic signed [W-1:0] put_value,
   input  logic                commit,
   output logic signed [W-1:0] active,
   output logic signed [W-1:0] shadow_next,
   output logic signed [W-1:0] active_next,
   output logic [D-1:0]        out
);

   localparam logic signed [W-1:0] NONE_W = W'(ROUTE_NONE);

   logic signed [W-1:0] shadow_r;
   logic signed [W-1:0] active_r;
   logic [D-1:0]        out_r;
   logic signed [W-1:0] shadow_next_s;
   logic signed [W-1:0] active_next_s;
   logic [D-1:0]        src_s;

   // Shadow entry update from put.
   always_comb begin
      shadow_next_s = shadow_r;
      if (put_hit) begin
         shadow_next_s = put_value;
      end else begin
         shadow_next_s = shadow_r;
      end
   end

   // Active entry update: commit takes the post-put shadow, so a put and a
   // commit at the same edge land together; legacy mode also writes on put.
   always_comb begin
      active_next_s = active_r;
      if (commit) begin
         active_next_s = shadow_next_s;
      end else if (put_hit && (IMMEDIATE != 0)) begin
         active_next_s = put_value;
      end else begin
         active_next_s = active_r;
      end
   end

   // Source select from the pre-edge active entry; -1 matches no channel and
   // therefore yields zero.
   always_comb begin
      src_s = {D{1'b0}};
      for (int i = 0; i < N; i++) begin
         src_s = (active_r == W'(i)) ? in[i*D +: D] : src_s;
      end
   end

   // Lane state registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         shadow_r <= NONE_W;
         active_r <= NONE_W;
         out_r    <= {D{1'b0}};
      end else begin
         shadow_r <= shadow_next_s;
         active_r <= active_next_s;
         out_r    <= src_s;
      end
   end

   assign active      = active_r;
   assign shadow_next = shadow_next_s;
   assign active_next = active_next_s;
   assign out         = out_r;

endmodule

// File: rtl/crossbar_staged.sv
// ---------------------------------------------------------------------------
// crossbar_staged
// N-input, M-output crossbar with D-bit channels and a double-buffered route
// table. put edits the shadow table, commit loads it into the active table.
// Ports:
//   clock    rising-edge clock
//   reset    synchronous, active-low reset
//   in       input channels, channel i = in[i*D +: D]
//   out      registered outputs, channel j = out[j*D +: D]
//   from     signed source index for put (out of range = unsubscribe)
//   to       signed destination index for put (out of range = ignored)
//   put      write shadow[to] at this edge
//   commit   load active from shadow at this edge
//   query    signed output index for readback
//   route    active[query], -1 when query is out of range (combinational)
//   pending  registered, 1 when shadow differs from active
// ---------------------------------------------------------------------------
module crossbar_staged
   import crossbar_staged_pkg::*;
#(
   parameter int W         = 3,
   parameter int N         = 4,
   parameter int M         = 4,
   parameter int D         = 1,
   parameter int IMMEDIATE = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N*D-1:0]      in,
   output logic [M*D-1:0]      out,
   input  logic signed [W-1:0] from,
   input  logic signed [W-1:0] to,
   input  logic                put,
   input  logic                commit,
   input  logic signed [W-1:0] query,
   output logic signed [W-1:0] route,
   output logic                pending
);

   localparam logic signed [W-1:0] NONE_W = W'(ROUTE_NONE);

   logic                to_ok_s;
   logic signed [W-1:0] put_value_s;
   logic [M-1:0]        put_hit_s;
   logic signed [W-1:0] active_s      [M];
   logic signed [W-1:0] shadow_next_s [M];
   logic signed [W-1:0] active_next_s [M];
   logic                diff_s;
   logic                pending_r;
   logic signed [W-1:0] route_s;

   // Put decode: normalise the source and select the target lane.
   always_comb begin
      to_ok_s     = idx_in_range(32'(to), 32'(M));
      put_value_s = W'(idx_normalise(32'(from), 32'(N)));
      put_hit_s   = {M{1'b0}};
      for (int j = 0; j < M; j++) begin
         put_hit_s[j] = put && to_ok_s && (to == W'(j));
      end
   end

   for (genvar j = 0; j < M; j++) begin : g_lane
      crossbar_route_reg #(
         .W         (W),
         .N         (N),
         .D         (D),
         .IMMEDIATE (IMMEDIATE)
      ) u_lane (
         .clock       (clock),
         .reset       (reset),
         .in          (in),
         .put_hit     (put_hit_s[j]),
         .put_value   (put_value_s),
         .commit      (commit),
         .active      (active_s[j]),
         .shadow_next (shadow_next_s[j]),
         .active_next (active_next_s[j]),
         .out         (out[j*D +: D])
      );
   end

   // Compare the post-edge tables so pending is exact in the following cycle.
   always_comb begin
      diff_s = 1'b0;
      for (int j = 0; j < M; j++) begin
         diff_s = diff_s | (shadow_next_s[j] != active_next_s[j]);
      end
   end

   // Pending flag register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending_r <= 1'b0;
      end else begin
         pending_r <= diff_s;
      end
   end

   // Readback of the active table only; put/commit never reach route directly.
   always_comb begin
      route_s = NONE_W;
      if (idx_in_range(32'(query), 32'(M))) begin
         for (int j = 0; j < M; j++) begin
            route_s = (query == W'(j)) ? active_s[j] : route_s;
         end
      end else begin
         route_s = NONE_W;
      end
   end

   assign pending = pending_r;
   assign route   = route_s;

endmodule
